dram_cmd_responder: RTL and testbench
=====================================

DRAM_CMD_RESPONDER -- requirements
Module: dram_cmd_responder

Interface
REQ-001 Parameter NUMBER_OF_BANKS, default 8, number of banks tracked.
REQ-002 Parameter NUMBER_OF_ROWS, default 128, rows per bank.
REQ-003 Parameter NUMBER_OF_COLS, default 8, columns per row.
REQ-004 Parameters T_RCD=3, T_CAS=2, T_RP=3, T_RFC=8: busy cycles for ACTIVATE, COLUMN, PRECHARGE, REFRESH; each SHALL be >=1.
REQ-005 Parameter REFRESH_INTERVAL, default 1024, cycles between refresh requests.
REQ-006 clk  input  1  single clock, rising edge.
REQ-007 rst_b  input  1  reset, asynchronous, active-low.
REQ-008 cmd_req  input  1  initiator command request, held high until acked.
REQ-009 cmd  input  2  00 ACTIVATE, 01 COLUMN, 10 REFRESH, 11 PRECHARGE.
REQ-010 bank_id / row_id / col_id  input  clog2(BANKS)/clog2(ROWS)/clog2(COLS)  command address.
REQ-011 cmd_ack  output  1  one-cycle completion pulse.
REQ-012 refresh_flag  output  1  refresh demanded of initiator.
REQ-013 protocol_err  output  1  one-cycle illegal-command pulse, coincident with cmd_ack.
REQ-014 col_valid  output  1  one-cycle pulse on legal COLUMN completion; col_bank/col_row/col_col outputs carry the access address.
REQ-015 bank_open  output  NUMBER_OF_BANKS  per-bank open-row flag.

Function
REQ-016 FSM states IDLE, BUSY, ACK.
REQ-017 IDLE: on cmd_req=1, latch cmd, bank_id, row_id and col_id; load timer with the command latency; go to BUSY. Inputs are ignored outside IDLE.
REQ-018 BUSY: decrement timer each cycle; when timer==1, go to ACK.
REQ-019 ACK: drive cmd_ack=1 for exactly one cycle, apply the bank-state update, go to IDLE. Request-to-ack latency is latency+1 cycles.
REQ-020 One cycle after ACK, IDLE SHALL not accept a new command, because the initiator drops cmd_req registered on cmd_ack. From the second IDLE cycle on, a high cmd_req is a new command.
REQ-021 ACTIVATE to a closed bank: set bank_open[b] and store open_row[b]=row_id. ACTIVATE to an open bank: protocol_err, no state change.
REQ-022 COLUMN to an open bank with latched row==open_row[b]: col_valid pulse with the latched address. COLUMN to a closed bank or a mismatched row: protocol_err, no col_valid.
REQ-023 PRECHARGE: clear bank_open[b]. PRECHARGE to a closed bank is legal and has no effect.
REQ-024 REFRESH with all banks closed: clear refresh_flag and reload the interval counter. REFRESH with any bank open: protocol_err; the flag stays set and the counter is not reloaded.
REQ-025 The interval counter decrements every cycle independent of FSM state. On reaching 0, set refresh_flag and hold it until a legal REFRESH ack; the counter stays at 0.
REQ-026 If the counter expires in the same cycle as a legal REFRESH ack, the ack wins: flag cleared, counter reloaded.
REQ-027 cmd_ack, protocol_err and col_valid SHALL be registered outputs.

Reset
REQ-028 rst_b low asynchronously forces: state IDLE, timer 0, interval counter REFRESH_INTERVAL, cmd_ack 0, protocol_err 0, col_valid 0, col_* 0, refresh_flag 0, bank_open all 0, open_row all 0.
REQ-029 Reset during BUSY or ACK SHALL abort the command with no ack; the first post-reset IDLE cycle accepts cmd_req.

Structure
REQ-030 Shared package dram_pkg holds the cmd encodings (CMD_ACT, CMD_COL, CMD_REF, CMD_PRE) and the responder state encodings. The controller FSM SHALL adopt the same constants.
REQ-031 One sub-module, dram_timer: loadable down-counter with load and value inputs and a zero output. It is instantiated twice, for the command timer and the refresh interval.

Verification
REQ-032 Reset, then ACTIVATE bank 2 row 5 at cycle 0 -> cmd_ack at cycle 4, bank_open=8'b0000_0100, no protocol_err.
REQ-033 Continue with COLUMN bank 2 row 5 col 3 -> ack 3 cycles after request, col_valid with col_bank=2, col_row=5, col_col=3. COLUMN bank 2 row 6 -> protocol_err, no col_valid.
REQ-034 ACTIVATE bank 2 again while open -> protocol_err, open_row[2] stays 5. Then PRECHARGE bank 2 -> bank_open=0 after ack.
REQ-035 REFRESH_INTERVAL=16, idle -> refresh_flag rises at cycle 16. REFRESH with bank 0 open -> protocol_err, flag held. PRECHARGE, then REFRESH -> ack after 9 cycles, flag cleared.
REQ-036 Reset asserted mid-BUSY of a REFRESH -> no cmd_ack, all outputs reset. The next ACTIVATE completes with normal latency.

Source files
------------

// File: rtl/dram_pkg.sv
// Shared command and responder-state encodings for the DRAM command path.
package dram_pkg;

   // Command encodings as driven on the cmd bus by the initiator.
   typedef enum logic [1:0] {
      CMD_ACT = 2'b00,
      CMD_COL = 2'b01,
      CMD_REF = 2'b10,
      CMD_PRE = 2'b11
   } cmd_e;

   // Responder FSM states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUSY = 2'b01,
      ST_ACK  = 2'b10
   } state_e;

   // Largest of four latencies; sizes the command timer.
   function automatic int max_of4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/dram_timer.sv
// Loadable down-counter that saturates at zero; load has priority over decrement.
module dram_timer
   import dram_pkg::*;
#(
   parameter int               WIDTH       = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             load,
   input  logic             en,
   input  logic [WIDTH-1:0] value,
   output logic [WIDTH-1:0] count,
   output logic             zero
);

   logic [WIDTH-1:0] count_reg;

   // Load a new value, otherwise count down while enabled and stop at zero.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         count_reg <= RESET_VALUE;
      end else if (load) begin
         count_reg <= value;
      end else if (en && (count_reg != '0)) begin
         count_reg <= count_reg - 1'b1;
      end
   end

   assign count = count_reg;
   assign zero  = (count_reg == '0);

endmodule

// File: rtl/dram_cmd_responder.sv
// DRAM command responder: accepts one command at a time, models its latency,
// tracks open banks/rows, flags protocol errors and demands periodic refresh.
module dram_cmd_responder
   import dram_pkg::*;
#(
   parameter int NUMBER_OF_BANKS  = 8,
   parameter int NUMBER_OF_ROWS   = 128,
   parameter int NUMBER_OF_COLS   = 8,
   parameter int T_RCD            = 3,
   parameter int T_CAS            = 2,
   parameter int T_RP             = 3,
   parameter int T_RFC            = 8,
   parameter int REFRESH_INTERVAL = 1024,
   localparam int BW = (NUMBER_OF_BANKS > 1) ? $clog2(NUMBER_OF_BANKS) : 1,
   localparam int RW = (NUMBER_OF_ROWS  > 1) ? $clog2(NUMBER_OF_ROWS)  : 1,
   localparam int CW = (NUMBER_OF_COLS  > 1) ? $clog2(NUMBER_OF_COLS)  : 1
) (
   input  logic                       clk,
   input  logic                       rst_b,
   input  logic                       cmd_req,
   input  logic [1:0]                 cmd,
   input  logic [BW-1:0]              bank_id,
   input  logic [RW-1:0]              row_id,
   input  logic [CW-1:0]              col_id,
   output logic                       cmd_ack,
   output logic                       refresh_flag,
   output logic                       protocol_err,
   output logic                       col_valid,
   output logic [BW-1:0]              col_bank,
   output logic [RW-1:0]              col_row,
   output logic [CW-1:0]              col_col,
   output logic [NUMBER_OF_BANKS-1:0] bank_open
);

   localparam int TW = $clog2(max_of4(T_RCD, T_CAS, T_RP, T_RFC) + 1);
   localparam int IW = $clog2(REFRESH_INTERVAL + 1);

   state_e                     state_reg;
   cmd_e                       cmd_reg;
   logic [BW-1:0]              bank_reg;
   logic [RW-1:0]              row_reg;
   logic [CW-1:0]              col_reg;
   logic                       gap_reg;
   logic                       cmd_ack_reg;
   logic                       perr_reg;
   logic                       colv_reg;
   logic [BW-1:0]              col_bank_reg;
   logic [RW-1:0]              col_row_reg;
   logic [CW-1:0]              col_col_reg;
   logic                       refresh_flag_reg;
   logic [NUMBER_OF_BANKS-1:0] bank_open_reg;
   logic [RW-1:0]              open_row_reg [NUMBER_OF_BANKS];

   logic          accept;
   logic [TW-1:0] lat_value;
   logic [TW-1:0] tmr_count;
   logic          tmr_zero;
   logic [IW-1:0] int_count;
   logic          int_zero;
   logic          finish;
   logic          ack_fire;
   logic          illegal;
   logic          ref_ok;
   logic          flag_set;

   // The cycle right after ACK is skipped: the initiator is still dropping cmd_req.
   assign accept   = (state_reg == ST_IDLE) && cmd_req && !gap_reg;
   // tmr_zero is a guard so BUSY can never stall if the timer somehow reads 0.
   assign finish   = (tmr_count == TW'(1)) || tmr_zero;
   assign ack_fire = (state_reg == ST_BUSY) && finish;
   assign ref_ok   = ack_fire && (cmd_reg == CMD_REF) && (bank_open_reg == '0);
   // Set the flag on the same edge the interval counter lands on zero.
   assign flag_set = int_zero || (int_count == IW'(1));

   // Latency to load for the incoming command.
   always_comb begin
      lat_value = TW'(T_RCD);
      case (cmd_e'(cmd))
         CMD_ACT: lat_value = TW'(T_RCD);
         CMD_COL: lat_value = TW'(T_CAS);
         CMD_REF: lat_value = TW'(T_RFC);
         CMD_PRE: lat_value = TW'(T_RP);
         default: lat_value = TW'(T_RCD);
      endcase
   end

   // Legality of the latched command against the current bank state.
   always_comb begin
      illegal = 1'b0;
      case (cmd_reg)
         CMD_ACT: illegal = bank_open_reg[bank_reg];
         CMD_COL: illegal = !(bank_open_reg[bank_reg] && (open_row_reg[bank_reg] == row_reg));
         CMD_REF: illegal = (bank_open_reg != '0);
         CMD_PRE: illegal = 1'b0;
         default: illegal = 1'b0;
      endcase
   end

   dram_timer #(
      .WIDTH       (TW),
      .RESET_VALUE ('0)
   ) u_cmd_timer (
      .clk   (clk),
      .rst_b (rst_b),
      .load  (accept),
      .en    (state_reg == ST_BUSY),
      .value (lat_value),
      .count (tmr_count),
      .zero  (tmr_zero)
   );

   dram_timer #(
      .WIDTH       (IW),
      .RESET_VALUE (IW'(REFRESH_INTERVAL))
   ) u_refresh_timer (
      .clk   (clk),
      .rst_b (rst_b),
      .load  (ref_ok),
      .en    (1'b1),
      .value (IW'(REFRESH_INTERVAL)),
      .count (int_count),
      .zero  (int_zero)
   );

   // Responder FSM with registered ack/error/column outputs.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_reg    <= ST_IDLE;
         cmd_reg      <= CMD_ACT;
         bank_reg     <= '0;
         row_reg      <= '0;
         col_reg      <= '0;
         gap_reg      <= 1'b0;
         cmd_ack_reg  <= 1'b0;
         perr_reg     <= 1'b0;
         colv_reg     <= 1'b0;
         col_bank_reg <= '0;
         col_row_reg  <= '0;
         col_col_reg  <= '0;
      end else begin
         cmd_ack_reg <= 1'b0;
         perr_reg    <= 1'b0;
         colv_reg    <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               gap_reg <= 1'b0;
               if (accept) begin
                  cmd_reg   <= cmd_e'(cmd);
                  bank_reg  <= bank_id;
                  row_reg   <= row_id;
                  col_reg   <= col_id;
                  state_reg <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (finish) begin
                  state_reg   <= ST_ACK;
                  cmd_ack_reg <= 1'b1;
                  perr_reg    <= illegal;
                  if ((cmd_reg == CMD_COL) && !illegal) begin
                     colv_reg     <= 1'b1;
                     col_bank_reg <= bank_reg;
                     col_row_reg  <= row_reg;
                     col_col_reg  <= col_reg;
                  end
               end
            end
            ST_ACK: begin
               state_reg <= ST_IDLE;
               gap_reg   <= 1'b1;
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   // Bank open/row bookkeeping, updated on the edge that raises cmd_ack.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         bank_open_reg <= '0;
         for (int i = 0; i < NUMBER_OF_BANKS; i++) begin
            open_row_reg[i] <= '0;
         end
      end else if (ack_fire && !illegal) begin
         case (cmd_reg)
            CMD_ACT: begin
               bank_open_reg[bank_reg] <= 1'b1;
               open_row_reg[bank_reg]  <= row_reg;
            end
            CMD_PRE: bank_open_reg[bank_reg] <= 1'b0;
            default: ;
         endcase
      end
   end

   // Refresh demand: a legal REFRESH ack beats a simultaneous expiry.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         refresh_flag_reg <= 1'b0;
      end else if (ref_ok) begin
         refresh_flag_reg <= 1'b0;
      end else if (flag_set) begin
         refresh_flag_reg <= 1'b1;
      end
   end

   assign cmd_ack      = cmd_ack_reg;
   assign protocol_err = perr_reg;
   assign col_valid    = colv_reg;
   assign col_bank     = col_bank_reg;
   assign col_row      = col_row_reg;
   assign col_col      = col_col_reg;
   assign refresh_flag = refresh_flag_reg;
   assign bank_open    = bank_open_reg;

endmodule

// File: tb/tb_dram_cmd_responder.sv
// Scoreboard bench for dram_cmd_responder: stimulus pushes expected acks,
// a negedge monitor pops and compares whenever cmd_ack is seen.
module tb_dram_cmd_responder;
   import dram_pkg::*;

   logic       clk = 1'b0;
   logic       rst_b = 1'b0;
   logic       cmd_req = 1'b0;
   logic [1:0] cmd = 2'b00;
   logic [2:0] bank_id = '0;
   logic [6:0] row_id = '0;
   logic [2:0] col_id = '0;
   logic       cmd_ack, refresh_flag, protocol_err, col_valid;
   logic [2:0] col_bank;
   logic [6:0] col_row;
   logic [2:0] col_col;
   logic [7:0] bank_open;

   typedef struct {
      int         ack_cyc;
      bit         perr;
      bit         colv;
      logic [2:0] cb;
      logic [6:0] cr;
      logic [2:0] cc;
      logic [7:0] bo;
      bit         flag;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   int   last_ack = 0;
   int   t;

   dram_cmd_responder #(
      .REFRESH_INTERVAL (16)
   ) dut (
      .clk          (clk),
      .rst_b        (rst_b),
      .cmd_req      (cmd_req),
      .cmd          (cmd),
      .bank_id      (bank_id),
      .row_id       (row_id),
      .col_id       (col_id),
      .cmd_ack      (cmd_ack),
      .refresh_flag (refresh_flag),
      .protocol_err (protocol_err),
      .col_valid    (col_valid),
      .col_bank     (col_bank),
      .col_row      (col_row),
      .col_col      (col_col),
      .bank_open    (bank_open)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!rst_b) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   // Advance to the negedge of cycle t (always moves at least one negedge).
   task automatic wait_cyc(input int target);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((cyc < target) && (n < 200));
   endtask

   // mode 0: start in the second IDLE cycle; mode 1: raise cmd_req in the
   // first IDLE cycle after an ack (accepted one cycle later); mode 2: now.
   task automatic issue(input logic [1:0] c, input int b, input int r, input int cl,
                        input int lat, input int mode, input bit perr, input bit colv,
                        input logic [7:0] bo, input bit flag);
      exp_t e;
      int   acc;
      bit   got;
      if (mode == 0) begin
         @(negedge clk);
         @(negedge clk);
      end else if (mode == 1) begin
         @(negedge clk);
      end
      acc = (mode == 1) ? cyc + 1 : cyc;
      e.ack_cyc = acc + lat + 1;
      e.perr = perr;
      e.colv = colv;
      e.cb   = 3'(b);
      e.cr   = 7'(r);
      e.cc   = 3'(cl);
      e.bo   = bo;
      e.flag = flag;
      q.push_back(e);
      cmd_req = 1'b1;
      cmd     = c;
      bank_id = 3'(b);
      row_id  = 7'(r);
      col_id  = 3'(cl);
      got = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (cmd_ack) begin
            got = 1'b1;
            break;
         end
      end
      chk("ack_seen", got, 1);
      last_ack = cyc;
      @(posedge clk);
      #1 cmd_req = 1'b0;
   endtask

   // Monitor: every ack is matched against the head of the scoreboard.
   always @(negedge clk) begin
      if (rst_b) begin
         if (cmd_ack) begin
            if (q.size() == 0) begin
               chk("unexpected_ack", 1, 0);
            end else begin
               mon_e = q.pop_front();
               chk("ack_cycle", cyc, mon_e.ack_cyc);
               chk("protocol_err", protocol_err, mon_e.perr);
               chk("col_valid", col_valid, mon_e.colv);
               chk("bank_open", bank_open, mon_e.bo);
               chk("refresh_flag", refresh_flag, mon_e.flag);
               if (mon_e.colv) begin
                  chk("col_bank", col_bank, mon_e.cb);
                  chk("col_row", col_row, mon_e.cr);
                  chk("col_col", col_col, mon_e.cc);
               end
               $display("ack cyc=%0d perr=%0b colv=%0b bank_open=%b flag=%0b",
                        cyc, protocol_err, col_valid, bank_open, refresh_flag);
            end
         end else begin
            chk("pulse_without_ack", {protocol_err, col_valid}, 2'b00);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state.
      repeat (2) @(negedge clk);
      chk("rst_cmd_ack", cmd_ack, 0);
      chk("rst_protocol_err", protocol_err, 0);
      chk("rst_col_valid", col_valid, 0);
      chk("rst_bank_open", bank_open, 0);
      chk("rst_refresh_flag", refresh_flag, 0);
      chk("rst_col_addr", {col_bank, col_row, col_col}, 0);
      rst_b = 1'b1;

      // Refresh demand after 16 idle cycles.
      wait_cyc(15);
      chk("flag_before_16", refresh_flag, 0);
      wait_cyc(16);
      chk("flag_at_16", refresh_flag, 1);

      // cmd, bank, row, col, latency, mode, perr, colv, bank_open, flag
      issue(CMD_ACT, 2, 5, 0, 3, 0, 0, 0, 8'h04, 1);
      issue(CMD_COL, 2, 5, 3, 2, 0, 0, 1, 8'h04, 1);
      issue(CMD_COL, 2, 6, 1, 2, 0, 1, 0, 8'h04, 1);
      issue(CMD_ACT, 2, 9, 0, 3, 0, 1, 0, 8'h04, 1);
      issue(CMD_COL, 2, 5, 7, 2, 1, 0, 1, 8'h04, 1);
      issue(CMD_PRE, 2, 0, 0, 3, 0, 0, 0, 8'h00, 1);
      issue(CMD_PRE, 2, 0, 0, 3, 0, 0, 0, 8'h00, 1);
      issue(CMD_COL, 2, 5, 0, 2, 0, 1, 0, 8'h00, 1);
      issue(CMD_ACT, 0, 1, 0, 3, 0, 0, 0, 8'h01, 1);
      issue(CMD_REF, 0, 0, 0, 8, 0, 1, 0, 8'h01, 1);
      issue(CMD_PRE, 0, 0, 0, 3, 0, 0, 0, 8'h00, 1);
      issue(CMD_REF, 0, 0, 0, 8, 0, 0, 0, 8'h00, 0);

      // Interval counter was reloaded by the legal REFRESH ack.
      t = last_ack;
      wait_cyc(t + 15);
      chk("reload_flag_low", refresh_flag, 0);
      wait_cyc(t + 16);
      chk("reload_flag_high", refresh_flag, 1);

      // Reset in the middle of a REFRESH.
      @(negedge clk);
      cmd_req = 1'b1;
      cmd     = CMD_REF;
      bank_id = '0;
      repeat (3) @(negedge clk);
      #2 rst_b = 1'b0;
      cmd_req = 1'b0;
      #1;
      chk("abort_cmd_ack", cmd_ack, 0);
      chk("abort_refresh_flag", refresh_flag, 0);
      chk("abort_bank_open", bank_open, 0);
      chk("abort_pulses", {protocol_err, col_valid}, 2'b00);
      repeat (2) @(negedge clk);
      rst_b = 1'b1;
      issue(CMD_ACT, 3, 7, 0, 3, 2, 0, 0, 8'h08, 0);

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
